// File: rtl/rfg_register_bank.sv
// Register-file target for the AXIS register protocol engine: NUM_REGS config
// registers, a pop-on-read byte FIFO filled from a local AXIS stream, and a status byte.
module rfg_register_bank #(
  parameter int          NUM_REGS    = 16,
  parameter int          FIFO_DEPTH  = 16,
  parameter logic [7:0]  FIFO_ADDR   = 8'h20,
  parameter logic [7:0]  STATUS_ADDR = 8'h21
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic [7:0]            rfg_address,
  input  logic [7:0]            rfg_write_value,
  input  logic                  rfg_write,
  input  logic                  rfg_write_last,
  input  logic                  rfg_read,
  output logic                  rfg_read_valid,
  output logic [7:0]            rfg_read_value,
  output logic [NUM_REGS*8-1:0] cfg_regs,
  output logic                  burst_done,
  input  logic [7:0]            s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int RW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [8:0]    NUM_REGS_W = 9'(NUM_REGS);
  localparam logic [LW-1:0] DEPTH_W    = LW'(FIFO_DEPTH);

  logic [7:0]    r_cfg [NUM_REGS];
  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_rd_ptr;
  logic [AW-1:0] r_wr_ptr;
  logic [LW-1:0] r_level;
  logic          r_underflow;
  logic          r_read_valid;
  logic [7:0]    r_read_value;
  logic          r_burst_done;

  logic          w_reg_hit;
  logic [RW-1:0] w_reg_idx;
  logic          w_empty;
  logic          w_full;
  logic          w_flush;
  logic          w_fifo_rd;
  logic          w_status_rd;
  logic          w_pop;
  logic          w_underflow;
  logic          w_push;
  logic [6:0]    w_level7;
  logic [7:0]    w_read_data;

  assign w_reg_hit   = ({1'b0, rfg_address} < NUM_REGS_W);
  assign w_reg_idx   = rfg_address[RW-1:0];
  assign w_empty     = (r_level == '0);
  assign w_full      = (r_level == DEPTH_W);
  assign w_flush     = rfg_write && (rfg_address == FIFO_ADDR);
  assign w_fifo_rd   = rfg_read && (rfg_address == FIFO_ADDR);
  assign w_status_rd = rfg_read && (rfg_address == STATUS_ADDR);
  assign w_pop       = w_fifo_rd && !w_empty;
  assign w_underflow = w_fifo_rd && w_empty;
  assign w_push      = s_axis_tvalid && !w_full;
  assign w_level7    = 7'(r_level);

  assign s_axis_tready  = !w_full;
  assign rfg_read_valid = r_read_valid;
  assign rfg_read_value = r_read_value;
  assign burst_done     = r_burst_done;

  for (genvar k = 0; k < NUM_REGS; k++) begin : g_cfg_out
    assign cfg_regs[8*k +: 8] = r_cfg[k];
  end

  // NOTE: every variable driven here gets a default first, so no path can leave it
  // unassigned and infer a latch.
  always_comb begin
    w_read_data = 8'h00;
    if (w_reg_hit)
      w_read_data = r_cfg[w_reg_idx];
    else if (rfg_address == FIFO_ADDR)
      w_read_data = w_empty ? 8'h00 : r_mem[r_rd_ptr];
    else if (rfg_address == STATUS_ADDR)
      w_read_data = {r_underflow, w_level7};
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values, which is what makes a same-cycle write+read return old data.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      for (int k = 0; k < NUM_REGS; k++) r_cfg[k] <= 8'h00;
      r_read_valid <= 1'b0;
      r_read_value <= 8'h00;
      r_burst_done <= 1'b0;
    end else begin
      if (rfg_write && w_reg_hit) r_cfg[w_reg_idx] <= rfg_write_value;
      r_read_valid <= rfg_read;
      if (rfg_read) r_read_value <= w_read_data;
      r_burst_done <= rfg_write && rfg_write_last;
    end
  end

  // Flush beats push and resets both pointers; pops and pushes otherwise combine freely.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_rd_ptr    <= '0;
      r_wr_ptr    <= '0;
      r_level     <= '0;
      r_underflow <= 1'b0;
    end else begin
      if (w_flush) begin
        r_rd_ptr <= '0;
        r_wr_ptr <= '0;
        r_level  <= '0;
      end else begin
        if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
        if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
        case ({w_push, w_pop})
          2'b10:   r_level <= r_level + LW'(1);
          2'b01:   r_level <= r_level - LW'(1);
          default: r_level <= r_level;
        endcase
      end
      if (w_underflow)      r_underflow <= 1'b1;
      else if (w_status_rd) r_underflow <= 1'b0;
    end
  end

  // NOTE: the storage array carries no reset; the level and pointers alone define
  // which entries are meaningful, so clearing the data would buy nothing.
  always_ff @(posedge aclk) begin
    if (w_push && !w_flush) r_mem[r_wr_ptr] <= s_axis_tdata;
  end

endmodule

// File: tb/tb_rfg_register_bank.sv
// Self-checking bench for rfg_register_bank: directed steps from the test plan, then
// random traffic, all compared against a queue/array reference model.
module tb_rfg_register_bank;

  localparam int         NUM_REGS    = 16;
  localparam int         FIFO_DEPTH  = 16;
  localparam logic [7:0] FIFO_ADDR   = 8'h20;
  localparam logic [7:0] STATUS_ADDR = 8'h21;

  logic                  aclk = 1'b0;
  logic                  aresetn;
  logic [7:0]            rfg_address;
  logic [7:0]            rfg_write_value;
  logic                  rfg_write;
  logic                  rfg_write_last;
  logic                  rfg_read;
  logic                  rfg_read_valid;
  logic [7:0]            rfg_read_value;
  logic [NUM_REGS*8-1:0] cfg_regs;
  logic                  burst_done;
  logic [7:0]            s_axis_tdata;
  logic                  s_axis_tvalid;
  logic                  s_axis_tready;

  rfg_register_bank #(
    .NUM_REGS(NUM_REGS), .FIFO_DEPTH(FIFO_DEPTH),
    .FIFO_ADDR(FIFO_ADDR), .STATUS_ADDR(STATUS_ADDR)
  ) dut (
    .aclk(aclk), .aresetn(aresetn),
    .rfg_address(rfg_address), .rfg_write_value(rfg_write_value),
    .rfg_write(rfg_write), .rfg_write_last(rfg_write_last),
    .rfg_read(rfg_read), .rfg_read_valid(rfg_read_valid),
    .rfg_read_value(rfg_read_value), .cfg_regs(cfg_regs),
    .burst_done(burst_done), .s_axis_tdata(s_axis_tdata),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready)
  );

  always #5 aclk = ~aclk;

  // Reference model: plain array of config bytes, a queue for the FIFO, one sticky bit.
  logic [7:0] m_cfg [NUM_REGS];
  logic [7:0] m_q [$];
  logic       m_uflow;
  logic [7:0] m_last_value;

  int tests_run = 0;
  int tests_failed = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < NUM_REGS; k++) m_cfg[k] = 8'h00;
    m_q.delete();
    m_uflow = 1'b0;
    m_last_value = 8'h00;
  endtask

  // One clock cycle: drive inputs, predict, clock, then compare after the edge.
  task automatic step(input logic rst, input logic wr, input logic rd,
                      input logic [7:0] addr, input logic [7:0] wdata, input logic last,
                      input logic tv, input logic [7:0] td);
    logic       exp_valid;
    logic       exp_burst;
    logic       do_push;
    logic       fifo_rd;
    logic [127:0] exp_cfg;
    aresetn = !rst; rfg_write = wr; rfg_read = rd; rfg_address = addr;
    rfg_write_value = wdata; rfg_write_last = last; s_axis_tvalid = tv; s_axis_tdata = td;
    #1;
    if (!rst) check("tready", s_axis_tready, m_q.size() < FIFO_DEPTH);

    if (rst) begin
      model_reset();
      exp_valid = 1'b0;
      exp_burst = 1'b0;
    end else begin
      exp_valid = rd;
      exp_burst = wr && last;
      do_push = tv && (m_q.size() < FIFO_DEPTH);
      fifo_rd = rd && (addr == FIFO_ADDR);
      if (rd) begin
        if (int'(addr) < NUM_REGS)       m_last_value = m_cfg[addr];
        else if (addr == FIFO_ADDR)      m_last_value = (m_q.size() == 0) ? 8'h00 : m_q[0];
        else if (addr == STATUS_ADDR)    m_last_value = {m_uflow, 7'(m_q.size())};
        else                             m_last_value = 8'h00;
      end
      if (fifo_rd && m_q.size() == 0)           m_uflow = 1'b1;
      else if (rd && addr == STATUS_ADDR)       m_uflow = 1'b0;
      if (wr && addr == FIFO_ADDR) begin
        m_q.delete();
      end else begin
        if (fifo_rd && m_q.size() != 0) void'(m_q.pop_front());
        if (do_push) m_q.push_back(td);
      end
      if (wr && int'(addr) < NUM_REGS) m_cfg[addr] = wdata;
    end

    @(posedge aclk);
    #1;
    check("read_valid", rfg_read_valid, exp_valid);
    check("read_value", rfg_read_value, m_last_value);
    check("burst_done", burst_done, exp_burst);
    exp_cfg = '0;
    for (int k = 0; k < NUM_REGS; k++) exp_cfg[8*k +: 8] = m_cfg[k];
    check("cfg_regs", cfg_regs, exp_cfg);
  endtask

  task automatic idle();                          step(0, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00); endtask
  task automatic wr(input logic [7:0] a, input logic [7:0] d, input logic l);
                                                  step(0, 1, 0, a, d, l, 0, 8'h00); endtask
  task automatic rd(input logic [7:0] a);         step(0, 0, 1, a, 8'h00, 0, 0, 8'h00); endtask
  task automatic push(input logic [7:0] d);       step(0, 0, 0, 8'h00, 8'h00, 0, 1, d); endtask

  initial begin
    logic [7:0] ra;
    int op;
    model_reset();
    aresetn = 1'b0; rfg_write = 0; rfg_read = 0; rfg_address = 0; rfg_write_value = 0;
    rfg_write_last = 0; s_axis_tvalid = 0; s_axis_tdata = 0;
    step(1, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00);
    step(1, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00);

    // Reset state: every config register and the status byte read zero.
    for (int a = 0; a < NUM_REGS; a++) rd(8'(a));
    rd(STATUS_ADDR);
    idle();

    // Write burst A0..A3 to 2..5, then read back-to-back.
    for (int i = 0; i < 4; i++) wr(8'(2 + i), 8'(8'hA0 + i), i == 3);
    idle();
    check("cfg_2_5", cfg_regs[47:16], 32'hA3A2A1A0);
    for (int i = 0; i < 4; i++) rd(8'(2 + i));

    // Fill the FIFO to full, attempt one overfill, drain it in order.
    for (int i = 0; i < 16; i++) push(8'(8'h11 + i));
    push(8'h99);
    rd(STATUS_ADDR);
    for (int i = 0; i < 16; i++) rd(FIFO_ADDR);
    rd(STATUS_ADDR);

    // Underflow sticky and read-to-clear.
    rd(FIFO_ADDR); rd(FIFO_ADDR);
    rd(STATUS_ADDR); rd(STATUS_ADDR);

    // Level 3 with simultaneous push and pop, then flush against a concurrent push.
    push(8'h31); push(8'h32); push(8'h33);
    for (int i = 0; i < 3; i++) step(0, 0, 1, FIFO_ADDR, 8'h00, 0, 1, 8'(8'h41 + i));
    rd(STATUS_ADDR);
    step(0, 1, 0, FIFO_ADDR, 8'h5A, 0, 1, 8'h77);
    rd(STATUS_ADDR);

    // Push and pop together on an empty FIFO: underflow plus a stored byte.
    step(0, 0, 1, FIFO_ADDR, 8'h00, 0, 1, 8'hC3);
    rd(STATUS_ADDR); rd(FIFO_ADDR);

    // Same-cycle write and read of one config register returns the old value.
    wr(8'h07, 8'h55, 0);
    step(0, 1, 1, 8'h07, 8'hAA, 1, 0, 8'h00);
    rd(8'h07);
    rd(8'h3C);

    // Reset in the middle of a read burst with the FIFO at level 5.
    for (int i = 0; i < 5; i++) push(8'(8'hD0 + i));
    rd(FIFO_ADDR); rd(FIFO_ADDR);
    step(1, 0, 1, FIFO_ADDR, 8'h00, 0, 0, 8'h00);
    idle();
    rd(STATUS_ADDR);
    check("cfg_after_reset", cfg_regs, '0);

    // Random traffic.
    for (int n = 0; n < 600; n++) begin
      op = int'($urandom_range(0, 9));
      case ($urandom_range(0, 3))
        0:       ra = FIFO_ADDR;
        1:       ra = STATUS_ADDR;
        2:       ra = 8'($urandom_range(0, 255));
        default: ra = 8'($urandom_range(0, NUM_REGS - 1));
      endcase
      if (op < 3)       step(0, 1, 0, ra, 8'($urandom), $urandom_range(0, 1) == 1,
                             $urandom_range(0, 1) == 1, 8'($urandom));
      else if (op < 8)  step(0, 0, 1, ra, 8'h00, 0, $urandom_range(0, 2) != 0, 8'($urandom));
      else if (op < 9)  step(0, 1, 1, ra, 8'($urandom), 0, $urandom_range(0, 1) == 1, 8'($urandom));
      else              step(0, 0, 0, ra, 8'h00, 0, 1, 8'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/rfg_register_bank.md
Name: rfg_register_bank

Overview:
- Register-file target on the rfg side of the AXIS register protocol engine. It consumes the engine's rfg_address, write and read strobes and returns one read byte per read strobe.
- Provides NUM_REGS 8-bit configuration registers, a pop-on-read data FIFO port filled from a local AXIS byte stream, and a status register.
- Sits between the protocol engine and the firmware core logic: configuration goes out, readout bytes come in.

Parameters:
NUM_REGS, 16, number of 8-bit config registers at addresses 0..NUM_REGS-1; legal 1..32
FIFO_DEPTH, 16, data FIFO depth in bytes; power of 2, legal 2..64
FIFO_ADDR, 8'h20, address of FIFO pop/flush port; must be >= NUM_REGS
STATUS_ADDR, 8'h21, address of status register; must be >= NUM_REGS and != FIFO_ADDR

Ports:
aclk  in  1  clock
aresetn  in  1  reset, synchronous, active-low
rfg_address  in  8  register address, valid with rfg_write or rfg_read
rfg_write_value  in  8  write data
rfg_write  in  1  write strobe, one byte per high cycle
rfg_write_last  in  1  marks last byte of a write burst, qualified by rfg_write
rfg_read  in  1  read strobe, one byte per high cycle
rfg_read_valid  out  1  read response valid
rfg_read_value  out  8  read response data
cfg_regs  out  NUM_REGS*8  config registers; reg k at [8k+7:8k]
burst_done  out  1  one-cycle pulse after the last byte of a write burst
s_axis_tdata  in  8  FIFO fill data
s_axis_tvalid  in  1  FIFO fill valid
s_axis_tready  out  1  FIFO fill ready; equals !full

Behaviour:
- Reset: cfg_regs=0, rfg_read_valid=0, rfg_read_value=8'h00, burst_done=0, FIFO empty (level 0), underflow sticky=0. s_axis_tready=1 while aresetn=0 is not required; tready is combinational !full, so it reads 1 after reset.
- Write (rfg_write=1 in cycle N); the effect is visible from cycle N+1:
  - address < NUM_REGS: reg[address] <= rfg_write_value.
  - FIFO_ADDR: flush FIFO (level 0, pointers 0); the data value is ignored.
  - STATUS_ADDR or unmapped address: ignored, no error.
- burst_done = 1 in cycle N+1 iff rfg_write && rfg_write_last in cycle N. Bursts with address increment need no special handling; every byte is an independent write.
- Read (rfg_read=1 in cycle N):
  - rfg_read_valid=1 in cycle N+1, with rfg_read_value registered in the same cycle.
  - Exactly one response per strobe. Back-to-back strobes give back-to-back responses and are never dropped or stalled; there is no backpressure toward the engine.
  - rfg_read_valid=0 in every cycle not following a strobe. rfg_read_value holds its last value.
- Read data by address:
  - address < NUM_REGS: reg[address].
  - FIFO_ADDR: FIFO head, then pop. If empty, return 8'h00, set underflow sticky, no pointer change.
  - STATUS_ADDR: {underflow, level[6:0]}. Read-to-clear: the returned byte includes the current sticky, and the sticky clears in N+1 unless a new underflow occurs in cycle N (set wins).
  - unmapped: 8'h00.
- Simultaneous write and read to the same config register in cycle N: the read returns the old value.
- FIFO fill: push when s_axis_tvalid && s_axis_tready. Level arithmetic is width clog2(FIFO_DEPTH)+1 and saturates at neither end, since it is guarded by full/empty.
- Same-cycle FIFO events:
  - Push + pop, non-empty: both occur, level unchanged, head returns the oldest byte.
  - Push + pop, empty: no bypass. The pop underflows (returns 00) and the pushed byte is stored, so level becomes 1.
  - Flush + push: flush wins, the incoming byte is discarded, and the level ends at 0.
  - Flush + FIFO read in the same cycle cannot occur, because the engine issues writes and reads exclusively. If it does occur, the read is served from the pre-flush head.
- FIFO storage: circular buffer. Read/write pointers wrap at FIFO_DEPTH. Full = level==FIFO_DEPTH.
- Reset mid-burst: all state returns to reset values in the next cycle. An outstanding response for a strobe in the reset cycle is not produced.

Test Plan:
- Reset then read addrs 0..15 plus STATUS_ADDR -> 17 responses, each 1 cycle after its strobe, all 8'h00.
- Write burst 8'hA0..8'hA3 to addr 2..5 with write_last on the 4th byte -> cfg_regs[47:16]=32'hA3A2A1A0, one burst_done pulse 1 cycle after the 4th write; read back 4 strobes back-to-back -> 4 consecutive valid cycles A0,A1,A2,A3.
- Push 8'h11..8'h20 (16 bytes) -> tready drops after the 16th byte and status reads 8'h10. 16 FIFO_ADDR reads return 11..20, after which status reads 8'h00.
- FIFO empty, read FIFO_ADDR twice -> returns 00,00. Status reads 8'h80, then the next status read gives 8'h00.
- Level 3, hold tvalid while reading FIFO_ADDR every cycle for 3 cycles -> level stays 3 and data order is preserved. Then write FIFO_ADDR together with a concurrent push -> status reads 8'h00.
- Assert aresetn=0 during a read burst with the FIFO at level 5 -> no further read_valid, cfg_regs=0, status reads 8'h00 after reset.
